cam_pattern_gen: RTL and testbench
==================================

// Module: cam_pattern_gen
// PURPOSE
//  Synthesizable OV7670-style camera source: generates CAM_pclk, CAM_vsync, CAM_href, CAM_px_data
//  with programmable geometry, blanking, bytes/pixel and test pattern. Drives test_cam's camera
//  inputs in simulation and on-board loopback (no sensor), replacing the hand-timed stimulus.
// PARAMETERS
//  LINE_PX   320  active pixels per line
//  ROWS      240  active lines per frame
//  H_BLANK   4    blank pclk periods after active bytes of each line
//  V_BLANK   4    blank lines at frame start; vsync high for first V_BLANK/2 of them (>=2, even)
//  BPP       2    bytes per pixel: 2 = RGB565 MSB first, 1 = high byte only
//  BAR_PX    40   pixel width of each colour bar (mode 0)
//  PCLK_DIV  2    clk cycles per pclk half-period (>=1)
// PORTS
//  clk          in   1   system clock
//  rst          in   1   asynchronous reset, active-low
//  enable       in   1   run request, sampled only at frame start
//  mode         in   2   0 bars, 1 solid, 2 x-ramp, 3 8x8 checker; sampled at frame start
//  solid_color  in   16  RGB565 colour for mode 1; sampled at frame start
//  CAM_pclk     out  1   generated pixel clock
//  CAM_vsync    out  1   frame sync, active high
//  CAM_href     out  1   line valid, active high
//  CAM_px_data  out  8   pixel byte, valid while href=1 at pclk rising edge
//  frame_done   out  1   1-clk pulse after last byte of last active line
//  frame_cnt    out  16  completed frames, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset (rst=0): pclk=0, vsync=0, href=0, px_data=0, frame_done=0, frame_cnt=0, all counters 0, state IDLE.
//  pclk: div_cnt counts 0..PCLK_DIV-1 every clk, toggles pclk at terminal; free-running in all states.
//  All camera outputs and counters update only on the clk edge where pclk goes 1->0 (fall tick);
//   stable across each rising edge. Line period = BPP*LINE_PX+H_BLANK ticks; col 0..that-1.
//  Frame = V_BLANK+ROWS lines; row 0..V_BLANK+ROWS-1; col and row wrap to 0.
//  FSM (transitions on fall tick):
//   IDLE   : outputs low. On row=0,col=0 with enable=1 -> latch mode/solid_color, VSYNC.
//   VSYNC  : vsync=1 for rows 0..V_BLANK/2-1 -> VBACK at row V_BLANK/2.
//   VBACK  : vsync=0, href=0 until row=V_BLANK -> ACTIVE.
//   ACTIVE : href=1 while col<BPP*LINE_PX, else 0 (no href in V blank). After last col of last row:
//            frame_done pulse, frame_cnt+1, row=0; enable=1 -> VSYNC (relatch), else IDLE.
//  In IDLE counters still run so restart aligns to frame start; enable deasserted mid-frame
//   has no effect until frame end.
//  Pixel x = col/BPP, y = row-V_BLANK. With BPP=2 byte 0 = pix[15:8], byte 1 = pix[7:0].
//  Patterns (RGB565): mode0 bar=(x/BAR_PX)%8 -> FFFF,FFE0,07FF,07E0,F81F,F800,001F,0000;
//   mode1 latched solid_color; mode2 pix = x[15:0] (zero-extended, truncates); mode3 pix =
//   (x[3]^y[3]) ? FFFF : 0000.
//  px_data = 0 whenever href=0.
//  Async reset mid-frame: all outputs low immediately; first frame after release begins from IDLE.
// TESTING (LINE_PX=4, ROWS=3, H_BLANK=4, V_BLANK=4, BPP=2, BAR_PX=1, PCLK_DIV=2)
//  Reset then enable=1: pclk period=4 clk; vsync high exactly 2 lines (24 pclk), href first rises at row 4.
//  Mode 0: each href line gives 8 bytes FF FF FF E0 07 FF 07 E0; href low for 4 pclk; 3 lines/frame.
//  Mode 1, solid_color=F81F, changed to 001F mid-frame: whole frame F8 1F, next frame 00 1F.
//  enable=0 mid-frame: current frame completes, frame_done pulses once, frame_cnt=1, then IDLE outputs low.
//  Mode 2 with BPP=1: bytes 00 00 00 00 per line (high byte of x); mode 3 with LINE_PX=16: byte 00 x8 then FF x8.
//  rst low during ACTIVE: vsync/href/pclk/px_data=0 same cycle; frame_cnt=0; clean frame after release.

Source files
------------

// File: rtl/cam_pattern_gen.sv
// OV7670-style camera source: free-running pixel clock plus vsync/href/byte stream
// with programmable geometry, blanking, bytes per pixel and a selectable test pattern.
module cam_pattern_gen #(
    parameter int LINE_PX  = 320,
    parameter int ROWS     = 240,
    parameter int H_BLANK  = 4,
    parameter int V_BLANK  = 4,
    parameter int BPP      = 2,
    parameter int BAR_PX   = 40,
    parameter int PCLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  mode,
    input  logic [15:0] solid_color,
    output logic        CAM_pclk,
    output logic        CAM_vsync,
    output logic        CAM_href,
    output logic [7:0]  CAM_px_data,
    output logic        frame_done,
    output logic [15:0] frame_cnt
);
    localparam int ACT_B   = BPP * LINE_PX;
    localparam int LINE_T  = ACT_B + H_BLANK;
    localparam int FRAME_R = V_BLANK + ROWS;
    localparam int COL_W   = $clog2(LINE_T + 1);
    localparam int ROW_W   = $clog2(FRAME_R + 1);
    localparam int DIV_W   = $clog2(PCLK_DIV + 1);

    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(LINE_T - 1);
    localparam logic [COL_W-1:0] COL_ACT    = COL_W'(ACT_B);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(FRAME_R - 1);
    localparam logic [ROW_W-1:0] ROW_VS_END = ROW_W'(V_BLANK / 2);
    localparam logic [ROW_W-1:0] ROW_ACT    = ROW_W'(V_BLANK);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(PCLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, VSYNC, VBACK, ACTIVE} state_t;

    state_t             state, state_next;
    logic [DIV_W-1:0]   div_cnt;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;
    logic [1:0]         mode_q;
    logic [15:0]        solid_q;
    logic               fall_tick;
    logic               at_origin;
    logic               relatch;
    logic               frame_end;
    logic [15:0]        x;
    logic [3:0]         y4;
    logic [15:0]        pix;
    logic               byte_lo;
    logic               href_d;
    logic [7:0]         data_d;

    assign fall_tick = (div_cnt == DIV_LAST) && CAM_pclk;
    assign at_origin = (row == '0) && (col == '0);

    // Counters name the position emitted on this fall tick; the state is resolved for it first.
    always_comb begin
        state_next = state;
        relatch    = 1'b0;
        frame_end  = 1'b0;
        case (state)
            IDLE: begin
                if (at_origin && enable) begin
                    state_next = VSYNC;
                    relatch    = 1'b1;
                end
            end
            VSYNC:  if (row == ROW_VS_END) state_next = VBACK;
            VBACK:  if (row == ROW_ACT)    state_next = ACTIVE;
            ACTIVE: begin
                if (at_origin) begin
                    frame_end = 1'b1;
                    if (enable) begin
                        state_next = VSYNC;
                        relatch    = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        x       = 16'(col) / 16'(BPP);
        y4      = 4'(row) - 4'(V_BLANK);
        byte_lo = (BPP == 2) && col[0];
        pix     = 16'h0000;
        case (mode_q)
            2'd0: begin
                case (3'(x / 16'(BAR_PX)))
                    3'd0: pix = 16'hFFFF;
                    3'd1: pix = 16'hFFE0;
                    3'd2: pix = 16'h07FF;
                    3'd3: pix = 16'h07E0;
                    3'd4: pix = 16'hF81F;
                    3'd5: pix = 16'hF800;
                    3'd6: pix = 16'h001F;
                    default: pix = 16'h0000;
                endcase
            end
            2'd1: pix = solid_q;
            2'd2: pix = x;
            default: pix = (x[3] ^ (y4 >= 4'd8)) ? 16'hFFFF : 16'h0000;
        endcase
        href_d = (state_next == ACTIVE) && (col < COL_ACT);
        data_d = href_d ? (byte_lo ? pix[7:0] : pix[15:8]) : 8'h00;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt     <= '0;
            CAM_pclk    <= 1'b0;
            state       <= IDLE;
            col         <= '0;
            row         <= '0;
            mode_q      <= 2'd0;
            solid_q     <= 16'h0000;
            CAM_vsync   <= 1'b0;
            CAM_href    <= 1'b0;
            CAM_px_data <= 8'h00;
            frame_done  <= 1'b0;
            frame_cnt   <= 16'h0000;
        end else begin
            frame_done <= 1'b0;
            if (div_cnt == DIV_LAST) begin
                div_cnt  <= '0;
                CAM_pclk <= ~CAM_pclk;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            if (fall_tick) begin
                state       <= state_next;
                CAM_vsync   <= (state_next == VSYNC);
                CAM_href    <= href_d;
                CAM_px_data <= data_d;
                if (relatch) begin
                    mode_q  <= mode;
                    solid_q <= solid_color;
                end
                if (frame_end) begin
                    frame_done <= 1'b1;
                    frame_cnt  <= frame_cnt + 16'd1;
                end
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_cam_pattern_gen.sv
// Directed bench for cam_pattern_gen: three small-geometry instances, a vector table of
// first-line byte patterns, and hand-written sequences for timing, stop and reset corners.
module tb_cam_pattern_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        enable;
    logic [1:0]  mode_v  [3];
    logic [15:0] solid_v [3];

    logic        p0, p1, p2, vs0, vs1, vs2, hr0, hr1, hr2, fd0, fd1, fd2;
    logic [7:0]  dt0, dt1, dt2;
    logic [15:0] fc0, fc1, fc2;
    logic [2:0]  pclk_v, vsync_v, href_v, fd_v;
    logic [2:0][7:0]  data_v;
    logic [2:0][15:0] fcnt_v;

    assign pclk_v  = {p2, p1, p0};
    assign vsync_v = {vs2, vs1, vs0};
    assign href_v  = {hr2, hr1, hr0};
    assign fd_v    = {fd2, fd1, fd0};
    assign data_v  = {dt2, dt1, dt0};
    assign fcnt_v  = {fc2, fc1, fc0};

    cam_pattern_gen #(.LINE_PX(4), .ROWS(3), .H_BLANK(4), .V_BLANK(4), .BPP(2), .BAR_PX(1), .PCLK_DIV(2)) u_dut0 (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode_v[0]), .solid_color(solid_v[0]),
        .CAM_pclk(p0), .CAM_vsync(vs0), .CAM_href(hr0), .CAM_px_data(dt0),
        .frame_done(fd0), .frame_cnt(fc0));

    cam_pattern_gen #(.LINE_PX(4), .ROWS(3), .H_BLANK(4), .V_BLANK(4), .BPP(1), .BAR_PX(1), .PCLK_DIV(2)) u_dut1 (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode_v[1]), .solid_color(solid_v[1]),
        .CAM_pclk(p1), .CAM_vsync(vs1), .CAM_href(hr1), .CAM_px_data(dt1),
        .frame_done(fd1), .frame_cnt(fc1));

    cam_pattern_gen #(.LINE_PX(16), .ROWS(3), .H_BLANK(4), .V_BLANK(4), .BPP(1), .BAR_PX(1), .PCLK_DIV(2)) u_dut2 (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode_v[2]), .solid_color(solid_v[2]),
        .CAM_pclk(p2), .CAM_vsync(vs2), .CAM_href(hr2), .CAM_px_data(dt2),
        .frame_done(fd2), .frame_cnt(fc2));

    typedef struct {
        string        name;
        int           d;
        logic [1:0]   mode;
        logic [15:0]  solid;
        int           n;
        logic [127:0] exp;
    } vec_t;

    vec_t       vecs [9];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] line_buf [0:31];
    int         line_n;
    int         last_wait;
    bit         stalled = 1'b0;
    int         fd_count = 0;
    int         fd_long  = 0;
    logic       fd_prev  = 1'b0;

    // frame_done pulses on instance 0, and pulses that last more than one clk
    always @(negedge clk) begin
        if (fd_v[0]) begin
            fd_count <= fd_count + 1;
            if (fd_prev) fd_long <= fd_long + 1;
        end
        fd_prev <= fd_v[0];
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Returns at the first negedge after a pclk rising edge.
    task automatic next_rise(input int d);
        logic prev;
        int   g;
        bit   done;
        prev = pclk_v[d];
        g    = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            g++;
            if (!prev && pclk_v[d]) begin
                done = 1'b1;
            end else begin
                prev = pclk_v[d];
                if (g >= 64) begin
                    if (!stalled) begin
                        stalled = 1'b1;
                        timeout("pclk_rise");
                    end
                    done = 1'b1;
                end
            end
        end
        last_wait = g;
    endtask

    task automatic wait_vsync(input int d, output int rises);
        logic prev;
        prev  = vsync_v[d];
        rises = 0;
        while (rises < 1000) begin
            next_rise(d);
            rises++;
            if (!prev && vsync_v[d]) return;
            prev = vsync_v[d];
        end
        timeout("vsync_rise");
    endtask

    task automatic get_line(input int d);
        int g;
        g = 0;
        while (!href_v[d] && g < 1000) begin
            next_rise(d);
            g++;
        end
        if (g >= 1000) timeout("href_rise");
        line_n = 0;
        while (href_v[d] && line_n < 32) begin
            line_buf[line_n] = data_v[d];
            line_n++;
            next_rise(d);
        end
    endtask

    function automatic int bad_bytes(input logic [127:0] exp, input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++)
            if (line_buf[i] !== exp[127 - 8*i -: 8]) bad++;
        return bad;
    endfunction

    function automatic int bad_solid(input logic [15:0] c);
        int bad;
        bad = 0;
        for (int i = 0; i < line_n; i++)
            if (line_buf[i] !== ((i % 2) ? c[7:0] : c[15:8])) bad++;
        return bad;
    endfunction

    initial begin
        int r;
        int cnt;
        int g;
        int fd_base;

        vecs[0] = '{name:"bars_d0",    d:0, mode:2'd0, solid:16'h0000, n:8,  exp:{64'hFFFF_FFE0_07FF_07E0, 64'h0}};
        vecs[1] = '{name:"solid_d0",   d:0, mode:2'd1, solid:16'hF81F, n:8,  exp:{64'hF81F_F81F_F81F_F81F, 64'h0}};
        vecs[2] = '{name:"solid2_d0",  d:0, mode:2'd1, solid:16'h1234, n:8,  exp:{64'h1234_1234_1234_1234, 64'h0}};
        vecs[3] = '{name:"ramp_d0",    d:0, mode:2'd2, solid:16'h0000, n:8,  exp:{64'h0000_0001_0002_0003, 64'h0}};
        vecs[4] = '{name:"ramp_bpp1",  d:1, mode:2'd2, solid:16'h0000, n:4,  exp:{32'h0000_0000, 96'h0}};
        vecs[5] = '{name:"solid_bpp1", d:1, mode:2'd1, solid:16'hA5C3, n:4,  exp:{32'hA5A5_A5A5, 96'h0}};
        vecs[6] = '{name:"check_16px", d:2, mode:2'd3, solid:16'h0000, n:16, exp:128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF};
        vecs[7] = '{name:"bars_16px",  d:2, mode:2'd0, solid:16'h0000, n:16, exp:128'hFFFF_0707_F8F8_0000_FFFF_0707_F8F8_0000};
        vecs[8] = '{name:"check_d0",   d:0, mode:2'd3, solid:16'h0000, n:8,  exp:128'h0};

        rst    = 1'b0;
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mode_v[i]  = 2'd0;
            solid_v[i] = 16'h0000;
        end
        repeat (3) @(negedge clk);
        check("rst_pclk",       32'(pclk_v[0]),  0);
        check("rst_vsync",      32'(vsync_v[0]), 0);
        check("rst_href",       32'(href_v[0]),  0);
        check("rst_data",       32'(data_v[0]),  0);
        check("rst_frame_done", 32'(fd_v[0]),    0);
        check("rst_frame_cnt",  32'(fcnt_v[0]),  0);

        // First frame after reset with bars
        enable    = 1'b1;
        mode_v[0] = 2'd0;
        mode_v[1] = 2'd2;
        mode_v[2] = 2'd3;
        rst       = 1'b1;
        wait_vsync(0, r);
        check("start_latency_rises", r, 2);
        cnt = 1;
        next_rise(0);
        while (vsync_v[0] && cnt < 200) begin
            cnt++;
            next_rise(0);
        end
        check("vsync_rises", cnt, 24);
        cnt = 0;
        while (!href_v[0] && cnt < 200) begin
            cnt++;
            next_rise(0);
        end
        check("vback_rises", cnt, 24);
        get_line(0);
        check("f1_line1_len", line_n, 8);
        check("f1_line1_bad", bad_bytes({64'hFFFF_FFE0_07FF_07E0, 64'h0}, 8), 0);
        cnt = 0;
        while (!href_v[0] && cnt < 100) begin
            cnt++;
            next_rise(0);
        end
        check("hblank_rises", cnt, 4);
        get_line(0);
        check("f1_line2_len", line_n, 8);
        get_line(0);
        check("f1_line3_len", line_n, 8);
        wait_vsync(0, r);
        check("tail_to_vsync_rises", r, 4);
        check("f1_frame_cnt", 32'(fcnt_v[0]), 1);
        next_rise(0);
        check("pclk_period_clk", last_wait, 4);

        // Table: each vector takes effect at the next frame start of its instance
        for (int k = 0; k < 9; k++) begin
            mode_v[vecs[k].d]  = vecs[k].mode;
            solid_v[vecs[k].d] = vecs[k].solid;
            wait_vsync(vecs[k].d, r);
            get_line(vecs[k].d);
            check({vecs[k].name, "_len"}, line_n, vecs[k].n);
            for (int i = 0; i < vecs[k].n; i++)
                check($sformatf("%s_b%0d", vecs[k].name, i), 32'(line_buf[i]), 32'(vecs[k].exp[127 - 8*i -: 8]));
        end

        // solid_color changed mid-frame only shows up in the next frame
        mode_v[0]  = 2'd1;
        solid_v[0] = 16'hF81F;
        wait_vsync(0, r);
        get_line(0);
        check("solidA_l1_len", line_n, 8);
        check("solidA_l1_bad", bad_solid(16'hF81F), 0);
        solid_v[0] = 16'h001F;
        get_line(0);
        check("solidA_l2_bad", bad_solid(16'hF81F), 0);
        get_line(0);
        check("solidA_l3_bad", bad_solid(16'hF81F), 0);
        wait_vsync(0, r);
        get_line(0);
        check("solidB_l1_len", line_n, 8);
        check("solidB_l1_bad", bad_solid(16'h001F), 0);

        // enable dropped mid-frame: frame completes, then stays idle
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst     = 1'b1;
        fd_base = fd_count;
        wait_vsync(0, r);
        check("restart_latency_rises", r, 2);
        enable = 1'b0;
        g = 0;
        while (!fd_v[0] && g < 2000) begin
            @(negedge clk);
            g++;
        end
        check("stop_frame_done_seen", 32'(g < 2000), 1);
        check("stop_frame_cnt", 32'(fcnt_v[0]), 1);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            next_rise(0);
            if (vsync_v[0] || href_v[0] || (data_v[0] != 8'h00)) cnt++;
        end
        check("idle_activity", cnt, 0);
        check("stop_frame_done_pulses", fd_count - fd_base, 1);

        // asynchronous reset while a line is being sent
        enable = 1'b1;
        g = 0;
        while (!href_v[0] && g < 400) begin
            next_rise(0);
            g++;
        end
        check("pre_rst_href", 32'(href_v[0]), 1);
        check("pre_rst_pclk", 32'(pclk_v[0]), 1);
        rst = 1'b0;
        #1;
        check("arst_pclk",      32'(pclk_v[0]),  0);
        check("arst_vsync",     32'(vsync_v[0]), 0);
        check("arst_href",      32'(href_v[0]),  0);
        check("arst_data",      32'(data_v[0]),  0);
        check("arst_frame_cnt", 32'(fcnt_v[0]),  0);
        @(negedge clk);
        rst = 1'b1;
        wait_vsync(0, r);
        check("post_rst_latency_rises", r, 2);
        cnt = 1;
        next_rise(0);
        while (vsync_v[0] && cnt < 200) begin
            cnt++;
            next_rise(0);
        end
        check("post_rst_vsync_rises", cnt, 24);
        get_line(0);
        check("post_rst_line_len", line_n, 8);
        check("post_rst_line_bad", bad_solid(16'h001F), 0);

        repeat (4) @(negedge clk);
        check("frame_done_width", fd_long, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
